// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
//   div_state_e : controller states (FIXUP is only reachable when
//                 SEQ_DIVIDER_SIGNED_EN is defined)
//   DIV_WIDTH   : default operand width
//   DIV_CNT_W   : iteration counter width for the default operand width
package seq_divider_pkg;

    localparam int unsigned DIV_WIDTH = 8;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_e;

endpackage

// File: rtl/seq_divider_8bit_trial_subtractor.sv
// Ripple-borrow subtractor a - b built from full-adder cells (b inverted,
// carry-in 1).
//   a, b   : minuend / subtrahend
//   diff   : a - b modulo 2^WIDTH
//   borrow : set when b > a (carry-out of the inverted-b adder is 0)
module trial_subtractor #(
    parameter int unsigned WIDTH = 9
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH-1:0] b_inv;
    logic [WIDTH:0]   carry;

    assign b_inv    = ~b;
    assign carry[0] = 1'b1;

    // One full-adder cell per bit
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign diff[i]      = a[i] ^ b_inv[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b_inv[i]) | (carry[i] & (a[i] ^ b_inv[i]));
    end

    assign borrow = ~carry[WIDTH];

endmodule

// File: rtl/seq_divider_8bit.sv
// Iterative restoring divider, one trial subtraction per cycle, with
// valid/ready handshakes on operands and results.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (in_ready only in IDLE)
//   dividend, divisor     : operands
//   out_valid / out_ready : result handshake (results held while DONE)
//   quotient, remainder   : result; divide-by-zero gives all ones / dividend
//   div_by_zero           : divisor was zero for this result
// Build option: define SEQ_DIVIDER_SIGNED_EN for two's-complement operands
// (truncating division, one extra FIXUP cycle for sign correction).
module seq_divider_8bit
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dsr_mag;
`endif

    // Datapath for one iteration: shift {rem,q} left, trial-subtract divisor
    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH:0]   sub_a, sub_b, trial;
    logic             trial_borrow;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    assign rem_sh = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    assign sub_a  = {1'b0, rem_sh};
    assign sub_b  = {1'b0, dsr_q};

    trial_subtractor #(
        .WIDTH (WIDTH + 1)
    ) u_trial_sub (
        .a      (sub_a),
        .b      (sub_b),
        .diff   (trial),
        .borrow (trial_borrow)
    );

    // With zero-extended inputs the diff MSB and the borrow are the same flag
    assign fits     = ~(trial[WIDTH] | trial_borrow);
    assign rem_next = fits ? trial[WIDTH-1:0] : rem_sh;
    assign quo_next = {quo_q[WIDTH-2:0], fits};

`ifdef SEQ_DIVIDER_SIGNED_EN
    assign dvd_mag = dividend[WIDTH-1] ? WIDTH'(0 - dividend) : dividend;
    assign dsr_mag = divisor[WIDTH-1]  ? WIDTH'(0 - divisor)  : divisor;
`endif

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                    quo_d   = dvd_mag;
                    dsr_d   = dsr_mag;
                    q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    r_neg_d = dividend[WIDTH-1];
`else
                    quo_d   = dividend;
                    dsr_d   = divisor;
`endif
                    rem_d   = '0;
                    cnt_d   = CNT_LAST;
                    if (divisor == '0) begin
                        // Result is fully known at accept time
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                rem_d = rem_next;
                quo_d = quo_next;
                if (cnt_q == '0) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                    state_d     = FIXUP;
`else
                    quotient_d  = quo_next;
                    remainder_d = rem_next;
                    state_d     = DONE;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef SEQ_DIVIDER_SIGNED_EN
            FIXUP: begin
                // Quotient sign follows sign mismatch, remainder follows dividend
                quotient_d  = q_neg_q ? WIDTH'(0 - quo_q) : quo_q;
                remainder_d = r_neg_q ? WIDTH'(0 - rem_q) : rem_q;
                state_d     = DONE;
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

`ifdef SEQ_DIVIDER_SIGNED_EN
    // Operand sign flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end
`endif

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Directed testbench for seq_divider_8bit: reset values, latency,
// unsigned edge values, divide-by-zero, backpressure, reset mid-operation,
// and (with SEQ_DIVIDER_SIGNED_EN) signed truncating division.
module tb_seq_divider_8bit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] dividend = 8'd0;
    logic [7:0] divisor = 8'd0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider_8bit u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cycles counted from the accepting edge; bounded so a stuck DUT still ends
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic edz, input int elat);
        int lat;
        check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 8'hA5;
        divisor  = 8'h5A;
        check({tag, ".in_ready_after_accept"}, 32'(in_ready), 32'd0);
        wait_valid(lat);
        check({tag, ".latency"}, 32'(lat), 32'(elat));
        check({tag, ".quotient"}, 32'(quotient), 32'(eq));
        check({tag, ".remainder"}, 32'(remainder), 32'(er));
        check({tag, ".div_by_zero"}, 32'(div_by_zero), 32'(edz));
        @(posedge clk);
        #1;
        check({tag, ".out_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.quotient", 32'(quotient), 32'd0);
        check("rst.remainder", 32'(remainder), 32'd0);
        check("rst.div_by_zero", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("dbz_5_0", 8'd5, 8'd0, 8'd255, 8'd5, 1'b1, 1);

`ifdef SEQ_DIVIDER_SIGNED_EN
        run_op("s_m100_7", 8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 10);
        run_op("s_m128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 10);
        run_op("s_100_m7", 8'd100, 8'hF9, 8'hF2, 8'd2, 1'b0, 10);
`else
        run_op("u_200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9);
        run_op("u_255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
        run_op("u_3_10", 8'd3, 8'd10, 8'd0, 8'd3, 1'b0, 9);
        run_op("u_0_9", 8'd0, 8'd9, 8'd0, 8'd0, 1'b0, 9);
        run_op("u_255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9);
        run_op("u_250_200", 8'd250, 8'd200, 8'd1, 8'd50, 1'b0, 9);

        // Backpressure: result held, new request waits for output handshake
        out_ready = 1'b0;
        dividend  = 8'd100;
        divisor   = 8'd3;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        dividend = 8'd7;
        divisor  = 8'd1;
        wait_valid(lat);
        check("bp.latency", 32'(lat), 32'd9);
        for (int i = 0; i < 5; i++) begin
            check("bp.hold_valid", 32'(out_valid), 32'd1);
            check("bp.hold_quotient", 32'(quotient), 32'd33);
            check("bp.hold_remainder", 32'(remainder), 32'd1);
            check("bp.hold_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp.out_valid_drop", 32'(out_valid), 32'd0);
        check("bp.in_ready_back", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp.second_accepted", 32'(in_ready), 32'd0);
        wait_valid(lat);
        check("bp.second_latency", 32'(lat), 32'd9);
        check("bp.second_quotient", 32'(quotient), 32'd7);
        check("bp.second_remainder", 32'(remainder), 32'd0);
        @(posedge clk);
        #1;

        // Reset after four BUSY iterations aborts the operation
        dividend = 8'd200;
        divisor  = 8'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst.out_valid", 32'(out_valid), 32'd0);
        check("mid_rst.in_ready", 32'(in_ready), 32'd1);
        check("mid_rst.quotient", 32'(quotient), 32'd0);
        check("mid_rst.remainder", 32'(remainder), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("u_50_6", 8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 9);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
